// File: rtl/lc3b_pkg.sv
// Shared definitions for the LC-3b memory responder: access encodings,
// FSM state encoding, latency bounds and the byte-lane helper.
package lc3b_pkg;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;
    localparam logic RW_READ   = 1'b0;
    localparam logic RW_WRITE  = 1'b1;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    // Byte lanes touched by a write: both for a word, otherwise the lane
    // selected by the byte address bit.
    function automatic logic [1:0] byte_en(input logic size, input logic a0);
        logic [1:0] be;
        case ({size, a0})
            2'b00:   be = 2'b01;
            2'b01:   be = 2'b10;
            2'b10:   be = 2'b11;
            2'b11:   be = 2'b11;
            default: be = 2'b00;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lc3b_mem_array.sv
// Single-port 2^ADDR_W x 16 storage with per-byte write enable and a
// registered read port. Read data holds until the next read is requested.
module lc3b_mem_array #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [1:0]        be,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);

    logic [15:0] mem_r [2**ADDR_W];
    logic [15:0] rdata_r;

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            if (be[0]) begin
                mem_r[addr][7:0] <= wdata[7:0];
            end
            if (be[1]) begin
                mem_r[addr][15:8] <= wdata[15:8];
            end
        end
    end

    // Registered read; the value is kept until the next read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_r <= 16'h0000;
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/lc3b_memory.sv
// LC-3b memory responder. Accepts a MAR/MDR access on MIO_EN, completes it
// after LATENCY cycles with a one-cycle R pulse.
// Optional feature macro: MEM_ALIGN_CHECK_EN (suppress and flag misaligned
// word accesses via ALIGN_ERR).
module lc3b_memory
    import lc3b_pkg::*;
#(
    parameter int LATENCY = 5,
    parameter int ADDR_W  = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic        DATA_SIZE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR_IN,
    output logic [15:0] MEM_OUT,
    output logic        R,
    output logic        ALIGN_ERR
);

    mem_state_e       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [ADDR_W:0]  mar_r;
    logic             rw_r;
    logic             size_r;
    logic [15:0]      mdr_r;
    logic             r_r;

    logic             accept_s;
    logic             enter_done_s;
    logic [ADDR_W:0]  acc_mar_s;
    logic             acc_rw_s;
    logic             acc_size_s;
    logic [15:0]      acc_mdr_s;
    logic             misalign_s;
    logic             mem_we_s;
    logic             mem_re_s;
    logic             unused_mar_s;

    // Address bits above the storage range alias and are discarded.
    assign unused_mar_s = ^MAR[15:ADDR_W+1];

    // Next-state and counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (MIO_EN) begin
                    accept_s  = 1'b1;
                    cnt_nxt_s = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end else begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                end
            end
            ST_BUSY: begin
                cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Access fields: live inputs when accepting straight into DONE, else latched.
    always_comb begin
        if (state_r == ST_IDLE) begin
            acc_mar_s  = MAR[ADDR_W:0];
            acc_rw_s   = R_W;
            acc_size_s = DATA_SIZE;
            acc_mdr_s  = MDR_IN;
        end else begin
            acc_mar_s  = mar_r;
            acc_rw_s   = rw_r;
            acc_size_s = size_r;
            acc_mdr_s  = mdr_r;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_s = (acc_size_s == SIZE_WORD) && acc_mar_s[0];
`else
    assign misalign_s = 1'b0;
`endif

    // The access happens on the edge entering DONE, unless reset wins that edge.
    assign enter_done_s = (state_nxt_s == ST_DONE) && (state_r != ST_DONE) && rst_n;
    assign mem_we_s     = enter_done_s && (acc_rw_s == RW_WRITE) && !misalign_s;
    assign mem_re_s     = enter_done_s && (acc_rw_s == RW_READ)  && !misalign_s;

    // State, counter, request latch and ready pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            mar_r   <= {(ADDR_W+1){1'b0}};
            rw_r    <= RW_READ;
            size_r  <= SIZE_BYTE;
            mdr_r   <= 16'h0000;
            r_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            r_r     <= enter_done_s;
            if (accept_s) begin
                mar_r  <= MAR[ADDR_W:0];
                rw_r   <= R_W;
                size_r <= DATA_SIZE;
                mdr_r  <= MDR_IN;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic align_err_r;

    // Misalignment flag, coincident with the ready pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            align_err_r <= 1'b0;
        end else begin
            align_err_r <= enter_done_s && misalign_s;
        end
    end

    assign ALIGN_ERR = align_err_r;
`else
    assign ALIGN_ERR = 1'b0;
`endif

    assign R = r_r;

    lc3b_mem_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we_s),
        .be    (byte_en(acc_size_s, acc_mar_s[0])),
        .re    (mem_re_s),
        .addr  (acc_mar_s[ADDR_W:1]),
        .wdata (acc_mdr_s),
        .rdata (MEM_OUT)
    );

endmodule

// File: tb/tb_lc3b_memory.sv
// Scoreboard bench for lc3b_memory: the driver pushes expected completions
// computed by a word-array reference model; a monitor pops on every R.
module tb_lc3b_memory;

    localparam int LAT = 5;
    localparam int AW  = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MIO_EN;
    logic        R_W;
    logic        DATA_SIZE;
    logic [15:0] MAR;
    logic [15:0] MDR_IN;
    logic [15:0] MEM_OUT;
    logic        R;
    logic        ALIGN_ERR;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic        align;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] model_mem [2**AW];
    logic [15:0] model_out;
    int          cyc;
    int          checks;
    int          errors;

    lc3b_memory #(.LATENCY(LAT), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .MIO_EN    (MIO_EN),
        .R_W       (R_W),
        .DATA_SIZE (DATA_SIZE),
        .MAR       (MAR),
        .MDR_IN    (MDR_IN),
        .MEM_OUT   (MEM_OUT),
        .R         (R),
        .ALIGN_ERR (ALIGN_ERR)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: apply one access, return expected MEM_OUT and flag.
    function automatic void model_access(input logic rw, input logic sz,
                                         input logic [15:0] mar, input logic [15:0] mdr,
                                         output logic [15:0] out, output logic al);
        int idx;
        logic misal;
        idx   = int'(mar[AW:1]);
        misal = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        misal = sz && mar[0];
`endif
        al = misal;
        if (!misal) begin
            if (!rw) begin
                model_out = model_mem[idx];
            end else if (sz) begin
                model_mem[idx] = mdr;
            end else if (mar[0]) begin
                model_mem[idx][15:8] = mdr[15:8];
            end else begin
                model_mem[idx][7:0] = mdr[7:0];
            end
        end
        out = model_out;
    endfunction

    // Issue one access; MIO_EN stays high for 'hold' extra cycles, then the
    // task waits until the cycle after R.
    task automatic access(input string nm, input logic rw, input logic sz,
                          input logic [15:0] mar, input logic [15:0] mdr, input int hold);
        exp_t e;
        int   start;
        @(posedge clk); #1;
        MIO_EN = 1'b1; R_W = rw; DATA_SIZE = sz; MAR = mar; MDR_IN = mdr;
        start = cyc;
        e.cyc = start + LAT;
        e.name = nm;
        model_access(rw, sz, mar, mdr, e.data, e.align);
        sb_q.push_back(e);
        @(posedge clk); #1;
        MDR_IN = 16'($urandom);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        MIO_EN = 1'b0;
        MAR = 16'($urandom);
        while (cyc < start + LAT + 1) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: every R pops one expectation; a missed R is also an error.
    always @(negedge clk) begin
        if (rst_n) begin
            if (R) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_r cyc=%0d MEM_OUT=%h required no R", cyc, MEM_OUT);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (cyc != e.cyc || MEM_OUT !== e.data || ALIGN_ERR !== e.align) begin
                        errors++;
                        $display("FAIL %s cyc=%0d MEM_OUT=%h ALIGN_ERR=%b required cyc=%0d MEM_OUT=%h ALIGN_ERR=%b",
                                 e.name, cyc, MEM_OUT, ALIGN_ERR, e.cyc, e.data, e.align);
                    end
                end
            end else begin
                if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_r_%s cyc=%0d R=0 required R=1 at cyc=%0d", e.name, cyc, e.cyc);
                end
                if (ALIGN_ERR !== 1'b0) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_align cyc=%0d ALIGN_ERR=%b required 0", cyc, ALIGN_ERR);
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, pending=%0d", sb_q.size());
        $fatal(1, "watchdog");
    end

    logic [15:0] pool [8];

    initial begin
        exp_t e0, e1;
        int   s;
        cyc = 0; checks = 0; errors = 0; model_out = 16'h0000;
        rst_n = 1'b0; MIO_EN = 1'b0; R_W = 1'b0; DATA_SIZE = 1'b0;
        MAR = 16'h0000; MDR_IN = 16'h0000;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (R !== 1'b0 || MEM_OUT !== 16'h0000 || ALIGN_ERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_state R=%b MEM_OUT=%h ALIGN_ERR=%b required 0/0000/0", R, MEM_OUT, ALIGN_ERR);
        end

        // Word write then read back.
        access("word_wr", 1'b1, 1'b1, 16'h0040, 16'h1234, 0);
        access("word_rd", 1'b0, 1'b1, 16'h0040, 16'h0000, 0);
        // Byte writes into both halves, then word read.
        access("byte_hi", 1'b1, 1'b0, 16'h0041, 16'hABAB, 1);
        access("byte_lo", 1'b1, 1'b0, 16'h0040, 16'hCDCD, 0);
        access("byte_rd", 1'b0, 1'b1, 16'h0040, 16'h0000, 0);
        // MIO_EN dropped in cycle 2 of an access.
        access("drop_c2", 1'b0, 1'b0, 16'h0041, 16'h0000, 2);
        // Aliasing of upper address bits.
        access("alias_wr", 1'b1, 1'b1, 16'h0002, 16'h5A5A, 0);
        access("alias_rd", 1'b0, 1'b1, 16'h2002, 16'h0000, 0);
        // Misaligned word write, then read of the containing word.
        access("mis_wr", 1'b1, 1'b1, 16'h0041, 16'hDEAD, 0);
        access("mis_rd", 1'b0, 1'b1, 16'h0040, 16'h0000, 0);

        // Back-to-back: MIO_EN held high; R in cycles 5 and 11 of the burst.
        @(posedge clk); #1;
        MIO_EN = 1'b1; R_W = 1'b0; DATA_SIZE = 1'b1; MAR = 16'h0002;
        s = cyc;
        e0.cyc = s + LAT; e0.name = "b2b_first";
        model_access(1'b0, 1'b1, 16'h0002, 16'h0000, e0.data, e0.align);
        sb_q.push_back(e0);
        e1.cyc = s + 2 * LAT + 1; e1.name = "b2b_second";
        model_access(1'b0, 1'b1, 16'h0002, 16'h0000, e1.data, e1.align);
        sb_q.push_back(e1);
        while (cyc < s + LAT + 2) begin
            @(posedge clk); #1;
        end
        MIO_EN = 1'b0;
        while (cyc < s + 2 * LAT + 3) begin
            @(posedge clk); #1;
        end

        // Reset in cycle 3 of a write: write dropped, no R.
        access("pre_zero", 1'b1, 1'b1, 16'h0010, 16'h0000, 0);
        @(posedge clk); #1;
        MIO_EN = 1'b1; R_W = 1'b1; DATA_SIZE = 1'b1; MAR = 16'h0010; MDR_IN = 16'hFFFF;
        s = cyc;
        @(posedge clk); #1;
        MIO_EN = 1'b0;
        while (cyc < s + 3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_out = 16'h0000;
        @(negedge clk);
        checks++;
        if (R !== 1'b0 || MEM_OUT !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_write R=%b MEM_OUT=%h required 0/0000", R, MEM_OUT);
        end
        repeat (LAT + 2) @(posedge clk);
        access("reset_rd", 1'b0, 1'b1, 16'h0010, 16'h0000, 0);

        // Randomized accesses over a small pool of initialised words.
        for (int i = 0; i < 8; i++) begin
            pool[i] = 16'($urandom_range(0, 2**AW - 1)) << 1;
            access("rnd_init", 1'b1, 1'b1, pool[i], 16'($urandom), 0);
        end
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            logic [7:0]  b;
            a = pool[$urandom_range(0, 7)] | {3'($urandom), 13'd0} | 16'($urandom_range(0, 1));
            b = 8'($urandom);
            access("rnd", 1'($urandom), 1'($urandom), a,
                   ($urandom_range(0, 1) == 0) ? 16'($urandom) : {b, b},
                   $urandom_range(0, LAT - 1));
        end

        repeat (LAT + 3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3b_memory.md
# lc3b_memory

Memory responder for the LC-3b datapath. It answers the CPU's MAR/MDR memory cycle: the CPU asserts MIO_EN with an address, direction and size, and this block performs a word or byte read or write after a fixed access latency, signalling completion with the ready flag R. It sits on the memory side of the CPU's memory interface, opposite the microsequencer states that wait on R.

## Interface
- LATENCY, 5, cycles from the first cycle of MIO_EN to the R cycle; legal range 1..15
- ADDR_W, 12, word-index width; storage is 2^ADDR_W 16-bit words
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  reset; synchronous and active-low
- MIO_EN  in  1  access request
- R_W  in  1  0 = read, 1 = write
- DATA_SIZE  in  1  0 = byte, 1 = word
- MAR  in  16  byte address
- MDR_IN  in  16  write data
- MEM_OUT  out  16  read data
- R  out  1  ready; one-cycle completion pulse
- ALIGN_ERR  out  1  misaligned word access flag (see Configuration)

## Operation
- FSM states IDLE, BUSY, DONE. Reset state IDLE.
- IDLE: MIO_EN=1 at an edge → accept. Latch MAR, R_W, DATA_SIZE, MDR_IN. Load counter with LATENCY-1. Go to BUSY, or to DONE if LATENCY=1.
- BUSY: decrement counter. At counter = 1 the edge goes to DONE. Inputs are ignored, including MIO_EN deasserting; an accepted access always completes.
- The access is performed on the edge that enters DONE:
  - read: MEM_OUT ← full word at index MAR[ADDR_W:1], both bytes regardless of size. The CPU does byte selection and sign extension.
  - word write: word ← MDR_IN.
  - byte write, MAR[0]=0: low byte ← MDR_IN[7:0]; high byte unchanged.
  - byte write, MAR[0]=1: high byte ← MDR_IN[15:8]; low byte unchanged. The CPU replicates the byte into both halves of MDR.
- DONE: R=1 for exactly this cycle. Next state is IDLE.
- MIO_EN still high in the first IDLE cycle after DONE starts a new access (back-to-back). The CPU must drop MIO_EN on the edge that ends the R cycle if it wants no further access.
- MAR[15:ADDR_W+1] are ignored, so addresses alias modulo 2^(ADDR_W+1) bytes.
- Write data is sampled at acceptance. Later MDR_IN changes do not affect the write.

## Timing
- Reset values: R=0, MEM_OUT=16'h0000, ALIGN_ERR=0, state IDLE, counter 0. Storage contents are not reset.
- rst_n=0 mid-access: at that edge, return to IDLE. A pending write is dropped and R is not asserted.
- MIO_EN first high in cycle 0 (IDLE) → R=1 in cycle LATENCY; MEM_OUT is valid from that cycle on.
- MEM_OUT holds its value until the next read completes; writes do not change it.
- Minimum access-to-access spacing is LATENCY+1 cycles.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A word access with MAR[0]=1 is not performed: no write, and MEM_OUT is unchanged.
  - R still pulses at the normal time, with ALIGN_ERR=1 in the same cycle.
- Not defined: MAR[0] is ignored for word accesses, and ALIGN_ERR is tied to 0.
- Byte accesses are never flagged.

## Structure
- Shared package lc3b_pkg holds:
  - SIZE_BYTE/SIZE_WORD and RW_READ/RW_WRITE constants
  - the memory FSM state encoding
  - LATENCY bounds
- Sub-module lc3b_mem_array: single-port 2^ADDR_W × 16 storage with a two-bit byte write enable and registered read. The FSM and counter stay in lc3b_memory.

## Test plan
All cases use LATENCY=5 and ADDR_W=12.
- Word write, then read: write MAR=16'h0040, MDR_IN=16'h1234, size=word; then read 16'h0040 → R in cycle 5 of each access, MEM_OUT=16'h1234.
- Byte writes: word 16'h1234 at 16'h0040; byte write MAR=16'h0041 with MDR_IN=16'hABAB, then MAR=16'h0040 with MDR_IN=16'hCDCD; word read → 16'hABCD.
- Latency and pulse width: MIO_EN held high continuously from cycle 0:
  - R=1 exactly in cycles 5 and 11, 0 elsewhere;
  - MIO_EN dropped at cycle 2 of an access still yields R in cycle 5.
- Reset mid-write: rst_n=0 in cycle 3 of a write of 16'hFFFF to 16'h0010 (old value 16'h0000) → R never asserted, MEM_OUT=0; a later read returns 16'h0000.
- Aliasing: write 16'h5A5A to MAR=16'h0002, read MAR=16'h2002 → 16'h5A5A.
- Alignment (with MEM_ALIGN_CHECK_EN): word write to 16'h0041 with 16'hDEAD → R=1 and ALIGN_ERR=1 in cycle 5; a word read at 16'h0040 is unchanged. Without the macro: the write lands at 16'h0040 and ALIGN_ERR stays 0.
